// File: rtl/ariane_pkg.sv
// -----------------------------------------------------------------------------
// ariane_pkg
// Shared front-end types for the branch history table (BHT) update path.
//   bht_update_t : resolved-branch update from a requester (valid, pc, taken)
//   bht_wr_t     : write command towards the BHT storage array
// The row field is sized for the largest table this slice supports
// (BHT_NR_ENTRIES). Smaller tables zero-extend their row index into it.
// -----------------------------------------------------------------------------
package ariane_pkg;

    localparam int unsigned INSTR_PER_FETCH = 2;
    localparam int unsigned VLEN            = 64;
    localparam int unsigned BHT_NR_ENTRIES  = 1024;
    localparam int unsigned BHT_ROW_W       = $clog2(BHT_NR_ENTRIES / INSTR_PER_FETCH);
    localparam int unsigned BHT_COL_W       = $clog2(INSTR_PER_FETCH);

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef struct packed {
        logic                 valid;
        logic                 clear;
        logic [BHT_ROW_W-1:0] row;
        logic [BHT_COL_W-1:0] col;
        logic                 taken;
    } bht_wr_t;

endpackage

// File: rtl/bht_update_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bht_update_ctrl_pkg
// Local types of the BHT update controller: FSM state encoding, the entry
// stored in the pending-update FIFO, and the round-robin pointer values.
// -----------------------------------------------------------------------------
package bht_update_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic [ariane_pkg::BHT_ROW_W-1:0] row;
        logic [ariane_pkg::BHT_COL_W-1:0] col;
        logic                             taken;
    } bht_entry_t;

    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

endpackage

// File: rtl/bht_update_ctrl_if.sv
// -----------------------------------------------------------------------------
// bht_update_ctrl_if
// Request/response bundle of the BHT update controller.
//   req_a / req_b             : update requests (valid, pc, taken)
//   req_a_ready / req_b_ready : acceptance, handshake completes on valid&ready
//   bht_wr                    : registered write command to the BHT array
// Handshake: a requester holds valid and its payload until it sees ready in the
// same cycle; an update is taken exactly in a cycle where valid and ready are
// both high, and ready never waits for valid to be sampled by a register.
// master = requester/array side, slave = controller.
// -----------------------------------------------------------------------------
interface bht_update_ctrl_if;
    import ariane_pkg::*;

    bht_update_t req_a;
    logic        req_a_ready;
    bht_update_t req_b;
    logic        req_b_ready;
    bht_wr_t     bht_wr;

    modport master (
        output req_a, req_b,
        input  req_a_ready, req_b_ready, bht_wr
    );

    modport slave (
        input  req_a, req_b,
        output req_a_ready, req_b_ready, bht_wr
    );

endinterface

// File: rtl/bht_update_fifo.sv
// -----------------------------------------------------------------------------
// bht_update_fifo
// Pending-update queue of DEPTH {row,col,taken} entries (DEPTH power of two).
// Ports: clk_i, rst_ni (sync, active low), flush_i (empties queue on the edge),
//        push_i/data_i, pop_i/data_o (head, show-ahead), full_o, empty_o.
// Push while full and pop while empty are ignored.
// -----------------------------------------------------------------------------
module bht_update_fifo
    import bht_update_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       push_i,
    input  bht_entry_t data_i,
    input  logic       pop_i,
    output bht_entry_t data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    bht_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + PTR_W'(1);
        if (do_pop)  rd_d = rd_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// -----------------------------------------------------------------------------
// bht_update_ctrl
// Serialises BHT updates from two requesters into one write per cycle and
// runs a whole-table clear sequence on flush.
// Ports: clk_i, rst_ni (sync, active low), flush_i (start/restart clear),
//        debug_mode_i (accept but drop updates), upd_if (slave: req_a/req_b
//        with readies, bht_wr command), busy_o (clear sequence running).
// NR_ENTRIES must be a power of two, a multiple of INSTR_PER_FETCH and no
// larger than ariane_pkg::BHT_NR_ENTRIES.
// -----------------------------------------------------------------------------
module bht_update_ctrl
    import ariane_pkg::*;
    import bht_update_ctrl_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             debug_mode_i,
    bht_update_ctrl_if.slave upd_if,
    output logic             busy_o
);
    localparam int unsigned     NR_ROWS       = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned     ROW_ADDR_BITS = $clog2(INSTR_PER_FETCH);
    localparam int unsigned     ROW_W         = $clog2(NR_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(NR_ROWS - 1);

    ctrl_state_e      state_q, state_d;
    logic [ROW_W-1:0] cnt_q, cnt_d;
    logic             rr_q, rr_d;
    bht_wr_t          pop_wr_q, pop_wr_d;
    bht_entry_t       push_entry, head_entry;
    logic             fifo_full, fifo_empty, push, pop;
    logic             ready_base, ready_a, ready_b, gnt_a, gnt_b;
    logic             unused_pc;

    // pc[0] and the bits above the row index do not address the table.
    function automatic bht_entry_t pc_to_entry(input bht_update_t u);
        bht_entry_t e;
        e.row   = BHT_ROW_W'(u.pc[ROW_W+ROW_ADDR_BITS:ROW_ADDR_BITS+1]);
        e.col   = u.pc[ROW_ADDR_BITS:1];
        e.taken = u.taken;
        return e;
    endfunction

    assign unused_pc = ^{upd_if.req_a.pc, upd_if.req_b.pc};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                if (flush_i) begin
                    cnt_d = '0;          // restart the sweep from row 0
                end else if (cnt_q == LAST_ROW) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ROW_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // While clearing, the write command is the sweep row; otherwise it is the
    // registered result of last cycle's pop (all zero when nothing popped).
    always_comb begin
        busy_o        = (state_q == ST_FLUSH);
        upd_if.bht_wr = pop_wr_q;
        if (state_q == ST_FLUSH) begin
            upd_if.bht_wr       = '0;
            upd_if.bht_wr.valid = 1'b1;
            upd_if.bht_wr.clear = 1'b1;
            upd_if.bht_wr.row   = BHT_ROW_W'(cnt_q);
        end
    end

    // ---------------- acceptance / arbitration ----------------
    // Base readiness uses registered state only. The other requester's valid
    // is needed solely to hold off the loser of a simultaneous request.
    assign ready_base         = rst_ni & (state_q == ST_IDLE) & ~flush_i & ~fifo_full;
    assign ready_a            = ready_base & ((rr_q == RR_A) | ~upd_if.req_b.valid);
    assign ready_b            = ready_base & ((rr_q == RR_B) | ~upd_if.req_a.valid);
    assign upd_if.req_a_ready = ready_a;
    assign upd_if.req_b_ready = ready_b;

    assign gnt_a      = upd_if.req_a.valid & ready_a;
    assign gnt_b      = upd_if.req_b.valid & ready_b;
    assign push       = (gnt_a | gnt_b) & ~debug_mode_i;
    assign push_entry = gnt_b ? pc_to_entry(upd_if.req_b) : pc_to_entry(upd_if.req_a);

    // A flush on this edge wipes the queue, so the head must not escape.
    assign pop = (state_q == ST_IDLE) & ~flush_i & ~fifo_empty;

    always_comb begin
        rr_d = rr_q;
        if (gnt_a)      rr_d = RR_B;
        else if (gnt_b) rr_d = RR_A;

        pop_wr_d = '0;
        if (pop) begin
            pop_wr_d.valid = 1'b1;
            pop_wr_d.row   = head_entry.row;
            pop_wr_d.col   = head_entry.col;
            pop_wr_d.taken = head_entry.taken;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q     <= RR_A;
            pop_wr_q <= '0;
        end else begin
            rr_q     <= rr_d;
            pop_wr_q <= pop_wr_d;
        end
    end

    bht_update_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_bht_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bht_update_ctrl
// Drives the controller cycle by cycle and compares readies, busy and the
// write command with a reference model built from the behavioural rules:
// a queue of pending updates, a sweep row while clearing, and a turn flag.
// -----------------------------------------------------------------------------
module tb_bht_update_ctrl;
    import ariane_pkg::*;

    localparam int unsigned NR_ENTRIES = 1024;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int          NR_ROWS    = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int          WR_W       = $bits(bht_wr_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic dbg;
    logic busy;

    always #5 clk = ~clk;

    bht_update_ctrl_if upd_if();

    bht_update_ctrl #(
        .NR_ENTRIES (NR_ENTRIES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .debug_mode_i (dbg),
        .upd_if       (upd_if),
        .busy_o       (busy)
    );

    // ---------------- scoreboard / model state ----------------
    logic [WR_W-1:0] exp_q[$];     // accepted updates not yet popped
    bit              m_busy;
    int              m_row;
    bit              m_pend_v;     // an update popped last cycle appears now
    logic [WR_W-1:0] m_pend;
    bit              m_turn_b;     // 1: requester B wins a tie

    int n_checks = 0;
    int n_fail   = 0;

    // observations for directed checks
    int      obs_busy, obs_clear, obs_wr, obs_rdy_busy, obs_ra;
    bht_wr_t last_wr;
    logic    last_busy;
    logic [5:0] gnt_seq;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WR_W-1:0] upd_to_wr(input logic [63:0] pc, input bit t);
        bht_wr_t w;
        w       = '0;
        w.valid = 1'b1;
        w.row   = BHT_ROW_W'((pc >> 2) % 64'(NR_ROWS));
        w.col   = BHT_COL_W'((pc >> 1) % 64'd2);
        w.taken = t;
        return w;
    endfunction

    function automatic void clear_obs();
        obs_busy = 0; obs_clear = 0; obs_wr = 0; obs_rdy_busy = 0; obs_ra = 0;
        gnt_seq = '0;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(input bit r, input bit f, input bit d,
                         input bit va, input logic [63:0] pa, input bit ta,
                         input bit vb, input logic [63:0] pb, input bit tb);
        bit      room, exp_ra, exp_rb;
        bht_wr_t exp_wr, got_wr;
        @(negedge clk);
        rst_n        = r;
        flush        = f;
        dbg          = d;
        upd_if.req_a = '{valid: va, pc: pa, taken: ta};
        upd_if.req_b = '{valid: vb, pc: pb, taken: tb};
        #1;
        room   = r && !m_busy && !f && (exp_q.size() < int'(FIFO_DEPTH));
        exp_ra = room && (!m_turn_b || !vb);
        exp_rb = room && (m_turn_b || !va);
        exp_wr = '0;
        if (m_busy) begin
            exp_wr.valid = 1'b1;
            exp_wr.clear = 1'b1;
            exp_wr.row   = BHT_ROW_W'(m_row);
        end else if (m_pend_v) begin
            exp_wr = m_pend;
        end
        got_wr = upd_if.bht_wr;
        check_eq("ready_a", 64'(upd_if.req_a_ready), 64'(exp_ra));
        check_eq("ready_b", 64'(upd_if.req_b_ready), 64'(exp_rb));
        check_eq("busy",    64'(busy),               64'(m_busy));
        check_eq("bht_wr",  64'(got_wr),             64'(exp_wr));
        last_wr   = got_wr;
        last_busy = busy;
        if (busy) obs_busy++;
        if (got_wr.valid && got_wr.clear) obs_clear++;
        if (got_wr.valid && !got_wr.clear) obs_wr++;
        if (busy && (upd_if.req_a_ready || upd_if.req_b_ready)) obs_rdy_busy++;
        if (upd_if.req_a_ready) obs_ra++;
        if (va && upd_if.req_a_ready)      gnt_seq = {gnt_seq[4:0], 1'b0};
        else if (vb && upd_if.req_b_ready) gnt_seq = {gnt_seq[4:0], 1'b1};
        @(posedge clk);
        // reference model step
        if (!r) begin
            exp_q.delete();
            m_busy = 0; m_row = 0; m_pend_v = 0; m_turn_b = 0;
        end else if (f) begin
            exp_q.delete();
            m_busy = 1; m_row = 0; m_pend_v = 0;
        end else if (m_busy) begin
            m_pend_v = 0;
            if (m_row == NR_ROWS - 1) m_busy = 0;
            else m_row++;
        end else begin
            if (exp_q.size() > 0) begin
                m_pend   = exp_q.pop_front();
                m_pend_v = 1;
            end else begin
                m_pend_v = 0;
            end
            if (va && exp_ra) begin
                m_turn_b = 1;
                if (!d) exp_q.push_back(upd_to_wr(pa, ta));
            end else if (vb && exp_rb) begin
                m_turn_b = 0;
                if (!d) exp_q.push_back(upd_to_wr(pb, tb));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, '0, 0, 0, '0, 0);
    endtask

    task automatic rnd_cycle(input bit r, input bit f, input bit d);
        cycle(r, f, d,
              $urandom_range(0, 9) < 7, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) < 7, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; flush = 1'b0; dbg = 1'b0;
        upd_if.req_a = '0;
        upd_if.req_b = '0;
        m_busy = 0; m_row = 0; m_pend_v = 0; m_pend = '0; m_turn_b = 0;
        clear_obs();
        repeat (2) @(posedge clk);

        // reset cycles with requests pending: readies must stay low
        rnd_cycle(0, 0, 0);
        rnd_cycle(0, 0, 0);
        idle(1);

        // single update lands two cycles after acceptance
        cycle(1, 0, 0, 1, 64'h46, 1, 0, '0, 0);
        idle(2);
        check_eq("pc46_valid", 64'(last_wr.valid), 64'd1);
        check_eq("pc46_row",   64'(last_wr.row),   64'h11);
        check_eq("pc46_col",   64'(last_wr.col),   64'd1);
        check_eq("pc46_taken", 64'(last_wr.taken), 64'd1);

        // both requesters for six cycles: alternate starting with A
        cycle(0, 0, 0, 0, '0, 0, 0, '0, 0);
        clear_obs();
        for (int i = 0; i < 6; i++)
            cycle(1, 0, 0, 1, {$urandom, $urandom}, 1'(i % 2), 1, {$urandom, $urandom}, 1'(i % 3 == 0));
        check_eq("rr_grants", 64'(gnt_seq), 64'b010101);
        idle(3);
        check_eq("rr_writes", 64'(obs_wr), 64'd6);

        // burst from both sides
        for (int i = 0; i < 5; i++) rnd_cycle(1, 0, 0);
        idle(3);

        // flush with traffic: full sweep of every row, no acceptance
        for (int i = 0; i < 3; i++) rnd_cycle(1, 0, 0);
        clear_obs();
        rnd_cycle(1, 1, 0);
        for (int i = 0; i < NR_ROWS + 8; i++) rnd_cycle(1, 0, 0);
        check_eq("flush_busy_cycles", 64'(obs_busy), 64'(NR_ROWS));
        check_eq("flush_clears",      64'(obs_clear), 64'(NR_ROWS));
        check_eq("flush_ready_low",   64'(obs_rdy_busy), 64'd0);
        idle(3);

        // second flush after 100 clear writes restarts the sweep
        clear_obs();
        rnd_cycle(1, 1, 0);
        for (int i = 0; i < 99; i++) rnd_cycle(1, 0, 0);
        rnd_cycle(1, 1, 0);
        for (int i = 0; i < NR_ROWS + 8; i++) rnd_cycle(1, 0, 0);
        check_eq("reflush_clears", 64'(obs_clear), 64'(NR_ROWS + 100));
        idle(3);

        // debug mode: handshake completes but nothing is written
        clear_obs();
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, {$urandom, $urandom}, 1, 0, '0, 0);
        idle(3);
        check_eq("dbg_ready", 64'(obs_ra), 64'd6);
        check_eq("dbg_no_wr", 64'(obs_wr), 64'd0);

        // reset in the middle of a sweep
        rnd_cycle(1, 1, 0);
        for (int i = 0; i < 50; i++) rnd_cycle(1, 0, 0);
        rnd_cycle(0, 0, 0);
        idle(1);
        check_eq("rst_mid_flush_busy", 64'(last_busy), 64'd0);
        check_eq("rst_mid_flush_wr",   64'(last_wr.valid), 64'd0);

        // random soak
        for (int i = 0; i < 3000; i++)
            rnd_cycle($urandom_range(0, 499) != 0, $urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0);
        idle(NR_ROWS + 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
